// File: rtl/aclk_pkg.sv
// Shared types and default parameters for the alarm-clock key-entry control path.
package aclk_pkg;

  localparam int DEF_KEY_W       = 4;
  localparam int DEF_NOKEY       = 10;
  localparam int DEF_TIMEOUT_SEC = 10;
  localparam int DIGITS_NEEDED   = 4;

  typedef logic [DEF_KEY_W-1:0] key_t;

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_e;

endpackage

// File: rtl/aclk_key_fsm_if.sv
// Keypad/button inputs and display/load controls between the key FSM and its neighbours.
interface aclk_key_fsm_if #(
  parameter int KEY_W = aclk_pkg::DEF_KEY_W
);
  logic             one_second;
  logic [KEY_W-1:0] key;
  logic             alarm_button;
  logic             time_button;
  logic             shift;
  logic             show_new_time;
  logic             show_a;
  logic             load_new_a;
  logic             load_new_c;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  shift, show_new_time, show_a, load_new_a, load_new_c
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output shift, show_new_time, show_a, load_new_a, load_new_c
  );
endinterface

// File: rtl/aclk_timeout_cnt.sv
// Inactivity counter: counts one_second pulses while enabled, flags the last one of the window.
module aclk_timeout_cnt
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = DEF_TIMEOUT_SEC
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  input  logic one_second_i,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at the last count so a timeout that is not acted on never wraps the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && one_second_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = enable_i && one_second_i && (cnt_q == LAST);

endmodule

// File: rtl/aclk_key_fsm.sv
// Key-entry control FSM for the alarm clock: shift pulses, load pulses and display select.
// Optional macro ACLK_KEY_FSM_DIGIT_COUNT_EN: buttons only honoured after four digits.
module aclk_key_fsm
  import aclk_pkg::*;
#(
  parameter int               KEY_W       = DEF_KEY_W,
  parameter logic [KEY_W-1:0] NOKEY       = KEY_W'(DEF_NOKEY),
  parameter int               TIMEOUT_SEC = DEF_TIMEOUT_SEC
) (
  input logic           clock,
  input logic           reset,
  aclk_key_fsm_if.slave io
);

  state_e state_q, state_d;
  logic   shift_q, show_new_time_q, show_a_q, load_new_a_q, load_new_c_q;
  logic   counting, timeout, key_pressed, btn_ok;

  assign key_pressed = (io.key != NOKEY);
  assign counting    = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

  aclk_timeout_cnt #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_timeout (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (!counting),
    .enable_i     (counting),
    .one_second_i (io.one_second),
    .timeout_o    (timeout)
  );

`ifdef ACLK_KEY_FSM_DIGIT_COUNT_EN
  logic [2:0] digits_q, digits_d;

  always_comb begin
    digits_d = digits_q;
    if (state_q == SHOW_TIME) begin
      digits_d = '0;
    end else if ((state_q == KEY_STORED) && (digits_q != 3'(DIGITS_NEEDED))) begin
      digits_d = digits_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign btn_ok = (digits_q == 3'(DIGITS_NEEDED));
`else
  assign btn_ok = 1'b1;
`endif

  // In KEY_ENTRY the alarm button outranks the time button, and a fresh key outranks timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (io.alarm_button)  state_d = SHOW_ALARM;
        else if (key_pressed) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed) state_d = KEY_ENTRY;
        else if (timeout) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (btn_ok && io.alarm_button)     state_d = SET_ALARM_TIME;
        else if (btn_ok && io.time_button) state_d = SET_CURRENT_TIME;
        else if (key_pressed)              state_d = KEY_STORED;
        else if (timeout)                  state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!io.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // Outputs are registered from the next state, so they always match the decode of state_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= SHOW_TIME;
      shift_q         <= 1'b0;
      show_new_time_q <= 1'b0;
      show_a_q        <= 1'b0;
      load_new_a_q    <= 1'b0;
      load_new_c_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= (state_d == KEY_STORED);
      show_new_time_q <= (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                         (state_d == KEY_ENTRY);
      show_a_q        <= (state_d == SHOW_ALARM);
      load_new_a_q    <= (state_d == SET_ALARM_TIME);
      load_new_c_q    <= (state_d == SET_CURRENT_TIME);
    end
  end

  assign io.shift         = shift_q;
  assign io.show_new_time = show_new_time_q;
  assign io.show_a        = show_a_q;
  assign io.load_new_a    = load_new_a_q;
  assign io.load_new_c    = load_new_c_q;

endmodule
